// File: rtl/btn_updown.sv
// Two debounced push-buttons (shared sample prescaler) drive an 8-bit
// wrapping up/down counter plus one-cycle press strobes.

module btn_debounce #(
  parameter int STABLE_N = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_pulse
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  localparam logic [3:0] STABLE_LAST = 4'(STABLE_N);

  logic [1:0] r_sync;
  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;
  logic [3:0] w_cnt_inc;
  logic       w_s;
  logic       w_press;
  logic       r_pulse;

  assign w_s       = r_sync[1];
  assign w_cnt_inc = r_cnt + 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer to one flop.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync  <= 2'b00;
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_pulse <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_pulse <= w_press;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_press      = 1'b0;
    if (i_tick) begin
      case (r_state)
        IDLE: begin
          if (w_s) begin
            w_next_state = PRESS_CHK;
            w_next_cnt   = 4'd1;
          end
        end
        PRESS_CHK: begin
          if (!w_s) begin
            w_next_state = IDLE;
            w_next_cnt   = 4'd0;
          end else if (w_cnt_inc == STABLE_LAST) begin
            w_next_state = HELD;
            w_next_cnt   = 4'd0;
            w_press      = 1'b1;
          end else begin
            w_next_cnt   = w_cnt_inc;
          end
        end
        HELD: begin
          if (!w_s) begin
            w_next_state = REL_CHK;
            w_next_cnt   = 4'd1;
          end
        end
        REL_CHK: begin
          if (w_s) begin
            w_next_state = HELD;
            w_next_cnt   = 4'd0;
          end else if (w_cnt_inc == STABLE_LAST) begin
            w_next_state = IDLE;
            w_next_cnt   = 4'd0;
          end else begin
            w_next_cnt   = w_cnt_inc;
          end
        end
        default: begin
          w_next_state = IDLE;
          w_next_cnt   = 4'd0;
        end
      endcase
    end
  end

  assign o_pulse = r_pulse;

endmodule

module btn_updown #(
  parameter int TICK_DIV = 1000000,
  parameter int STABLE_N = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  output logic [7:0] COUNT,
  output logic       UP_PULSE,
  output logic       DOWN_PULSE
);

  localparam logic [26:0] TICK_LAST = 27'(TICK_DIV - 1);

  logic [26:0] r_presc;
  logic        w_tick;
  logic [7:0]  r_count;
  logic        w_up_pulse;
  logic        w_down_pulse;

  assign w_tick = (r_presc == TICK_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_presc <= 27'd0;
    end else if (w_tick) begin
      r_presc <= 27'd0;
    end else begin
      r_presc <= r_presc + 27'd1;
    end
  end

  btn_debounce #(.STABLE_N(STABLE_N)) u_up (
    .CLK     (CLK),
    .RST     (RST),
    .i_tick  (w_tick),
    .i_btn   (BTN_UP),
    .o_pulse (w_up_pulse)
  );

  btn_debounce #(.STABLE_N(STABLE_N)) u_down (
    .CLK     (CLK),
    .RST     (RST),
    .i_tick  (w_tick),
    .i_btn   (BTN_DOWN),
    .o_pulse (w_down_pulse)
  );

  // The count moves at the edge that closes a strobe cycle; simultaneous
  // up and down strobes cancel out.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_count <= 8'h00;
    end else begin
      case ({w_up_pulse, w_down_pulse})
        2'b10:   r_count <= r_count + 8'd1;
        2'b01:   r_count <= r_count - 8'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign COUNT      = r_count;
  assign UP_PULSE   = w_up_pulse;
  assign DOWN_PULSE = w_down_pulse;

endmodule

// File: doc/btn_updown.md
BTN_UPDOWN -- requirements
Module: btn_updown

Interface
REQ-001 Parameter TICK_DIV, default 1000000, is the sample-tick divisor in CLK cycles (10 ms at 100 MHz); legal range 2..2^27-1.
REQ-002 Parameter STABLE_N, default 4, is the number of consecutive equal samples that confirm a level change; legal range 2..15.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 BTN_UP  input  1  raw, asynchronous, bouncing push-button, high = pressed.
REQ-006 BTN_DOWN  input  1  raw, asynchronous, bouncing push-button, high = pressed.
REQ-007 COUNT  output  8  registered up/down press count, drives the LED bank.
REQ-008 UP_PULSE  output  1  registered one-cycle strobe on each confirmed BTN_UP press.
REQ-009 DOWN_PULSE  output  1  registered one-cycle strobe on each confirmed BTN_DOWN press.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer; the second flop output, s, is the only form of the button seen by downstream logic.
REQ-011 A shared 27-bit prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; internal TICK is high for exactly the one cycle in which the prescaler equals TICK_DIV-1.
REQ-012 Each button SHALL have an independent FSM with states IDLE, PRESS_CHK, HELD, REL_CHK and a 4-bit stable counter CNT; state and CNT change only in TICK cycles.
REQ-013 In IDLE on TICK, s=1 SHALL move the FSM to PRESS_CHK with CNT=1; s=0 SHALL keep it in IDLE.
REQ-014 In PRESS_CHK on TICK, s=0 SHALL move the FSM to IDLE with CNT=0; with s=1, CNT+1==STABLE_N SHALL move it to HELD with CNT=0, otherwise CNT increments.
REQ-015 In HELD on TICK, s=0 SHALL move the FSM to REL_CHK with CNT=1; s=1 SHALL keep it in HELD.
REQ-016 In REL_CHK on TICK, s=1 SHALL move the FSM to HELD with CNT=0; with s=0, CNT+1==STABLE_N SHALL move it to IDLE with CNT=0, otherwise CNT increments.
REQ-017 The pulse output SHALL be high for exactly the one cycle immediately following the PRESS_CHK->HELD edge and low in every other cycle; release never pulses.
REQ-018 A held button SHALL produce exactly one pulse regardless of hold duration.
REQ-019 Press latency, measured from a clean BTN rising edge to pulse assertion, SHALL be 2 synchronizer cycles + STABLE_N TICKs + 1 cycle, i.e. at most 3 + STABLE_N*TICK_DIV cycles.
REQ-020 COUNT SHALL update at the clock edge that ends a pulse cycle: UP only -> +1 mod 256; DOWN only -> -1 mod 256; both or neither -> unchanged.
REQ-021 COUNT SHALL wrap 0xFF->0x00 on up and 0x00->0xFF on down with no saturation and no flag.
REQ-022 Bounce shorter than STABLE_N consecutive ticks SHALL produce no pulse and no COUNT change.

Reset
REQ-023 RST low SHALL immediately force COUNT=0x00, UP_PULSE=0, DOWN_PULSE=0, prescaler=0, synchronizers=0, both FSMs=IDLE and CNT=0.
REQ-024 A button still held when RST deasserts SHALL be treated as a new press and pulse once after the REQ-019 latency.
REQ-025 Deassertion of RST SHALL be synchronized externally; this block applies no internal reset stretching.

Verification (TICK_DIV=4, STABLE_N=3)
REQ-026 Reset, then BTN_UP held high for 200 cycles -> exactly one UP_PULSE within 15 cycles of the rising edge; COUNT ends at 0x01.
REQ-027 BTN_UP toggled every 4 cycles for 100 cycles, then low -> UP_PULSE never asserts; COUNT stays 0x00.
REQ-028 From reset, one clean BTN_DOWN press and release -> COUNT=0xFF; then 1 clean BTN_UP press -> COUNT=0x00.
REQ-029 BTN_UP and BTN_DOWN rise in the same cycle and both stay high -> both pulses assert in the same cycle; COUNT unchanged at its prior value.
REQ-030 COUNT=0x05, BTN_UP in HELD, RST pulsed low for 3 cycles with BTN_UP still high -> outputs 0 during reset; one UP_PULSE after release of RST; COUNT=0x01.
REQ-031 256 clean BTN_UP presses from reset -> COUNT returns to 0x00 with exactly 256 UP_PULSE strobes.
